// File: rtl/detector_trigger_arbiter_if.sv
// Request/grant/status bundle between the trigger requesters and the detector trigger arbiter.
interface detector_trigger_arbiter_if #(parameter int CNT_W = 16);
  logic             enable;
  logic             calib_req;
  logic             shot_req;
  logic             detector_ready;
  logic             trigger_out;
  logic             calib_grant;
  logic             shot_grant;
  logic             busy;
  logic [1:0]       arb_state;
  logic [CNT_W-1:0] calib_count;
  logic [CNT_W-1:0] shot_count;
  logic [CNT_W-1:0] drop_count;

  modport slave (
    input  enable, calib_req, shot_req, detector_ready,
    output trigger_out, calib_grant, shot_grant, busy, arb_state,
           calib_count, shot_count, drop_count
  );

  modport master (
    output enable, calib_req, shot_req, detector_ready,
    input  trigger_out, calib_grant, shot_grant, busy, arb_state,
           calib_count, shot_count, drop_count
  );
endinterface

// File: rtl/detector_trigger_arbiter.sv
// Shares the detector trigger line between calibration and shot requesters (shot wins),
// emits a fixed-width pulse, then enforces a dead time and the detector-ready handshake.
module detector_trigger_arbiter #(
  parameter int PULSE_WIDTH    = 20,
  parameter int HOLDOFF_CYCLES = 1_280_000,
  parameter int CNT_W          = 16
) (
  input logic                       clock,
  input logic                       reset_signal,
  detector_trigger_arbiter_if.slave bus
);
  localparam int PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);
  localparam int CALIB = 0;
  localparam int SHOT  = 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE      = 2'd1,
    HOLDOFF    = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       req, req_q, rise, pend, pend_nxt, grant, drop;
  logic [1:0]       drop_inc;
  logic [1:0]       rdy_sync;
  logic             ready_sync;
  logic [PW_W-1:0]  pw_cnt;
  logic [HO_W-1:0]  ho_cnt;
  logic             trig_q, calib_grant_q, shot_grant_q;
  logic [CNT_W-1:0] calib_cnt, shot_cnt, drop_cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign req        = {bus.shot_req, bus.calib_req};
  assign rise       = req & ~req_q;
  assign ready_sync = rdy_sync[1];

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    case (state)
      IDLE: begin
        if (bus.enable && ready_sync && (|pend)) begin
          state_nxt = PULSE;
          if (pend[SHOT]) grant[SHOT]  = 1'b1;
          else            grant[CALIB] = 1'b1;
        end
      end
      PULSE:      if (pw_cnt == PW_W'(PULSE_WIDTH - 1))    state_nxt = HOLDOFF;
      HOLDOFF:    if (ho_cnt == HO_W'(HOLDOFF_CYCLES - 1)) state_nxt = WAIT_READY;
      WAIT_READY: if (ready_sync)                          state_nxt = IDLE;
      default:                                             state_nxt = IDLE;
    endcase
  end

  // A grant frees the slot in the same cycle, so a coincident new edge re-arms it instead of dropping.
  always_comb begin
    pend_nxt = (pend & ~grant) | rise;
    drop     = rise & pend & ~grant;
    drop_inc = {1'b0, drop[CALIB]} + {1'b0, drop[SHOT]};
  end

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      req_q         <= '0;
      pend          <= '0;
      rdy_sync      <= '0;
      pw_cnt        <= '0;
      ho_cnt        <= '0;
      trig_q        <= 1'b0;
      calib_grant_q <= 1'b0;
      shot_grant_q  <= 1'b0;
      calib_cnt     <= '0;
      shot_cnt      <= '0;
      drop_cnt      <= '0;
    end else begin
      req_q         <= req;
      pend          <= pend_nxt;
      rdy_sync      <= {rdy_sync[0], bus.detector_ready};
      pw_cnt        <= (state == PULSE && state_nxt == PULSE) ? pw_cnt + PW_W'(1) : '0;
      ho_cnt        <= (state == HOLDOFF && state_nxt == HOLDOFF) ? ho_cnt + HO_W'(1) : '0;
      trig_q        <= (state_nxt == PULSE);
      calib_grant_q <= grant[CALIB];
      shot_grant_q  <= grant[SHOT];
      calib_cnt     <= sat_add(calib_cnt, {1'b0, grant[CALIB]});
      shot_cnt      <= sat_add(shot_cnt, {1'b0, grant[SHOT]});
      drop_cnt      <= sat_add(drop_cnt, drop_inc);
    end
  end

  assign bus.trigger_out = trig_q;
  assign bus.calib_grant = calib_grant_q;
  assign bus.shot_grant  = shot_grant_q;
  assign bus.busy        = (state != IDLE);
  assign bus.arb_state   = state;
  assign bus.calib_count = calib_cnt;
  assign bus.shot_count  = shot_cnt;
  assign bus.drop_count  = drop_cnt;
endmodule

// File: tb/tb_detector_trigger_arbiter.sv
// Randomised + directed bench for detector_trigger_arbiter with a timestamp-based reference model.
module tb_detector_trigger_arbiter;
  localparam int PW   = 4;
  localparam int HO   = 10;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  typedef struct {
    bit          shot;
    int unsigned edge_n;
    int unsigned cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset_signal;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  detector_trigger_arbiter_if #(.CNT_W(CW)) ifc ();

  detector_trigger_arbiter #(
    .PULSE_WIDTH(PW), .HOLDOFF_CYCLES(HO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .bus(ifc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference model: grants are timestamped, and the arbiter phase is derived from
  // the distance to the last grant rather than from any state register.
  int unsigned n = 0, g = 0;
  bit          m_idle = 1'b1, pc = 1'b0, ps = 1'b0, cq = 1'b0, sq = 1'b0;
  bit          rh1 = 1'b0, rh2 = 1'b0;
  int unsigned mc = 0, ms = 0, md = 0, exp_state = 0;
  bit          rs, ec, es, gc, gs;

  always @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      m_idle = 1'b1; pc = 1'b0; ps = 1'b0; cq = 1'b0; sq = 1'b0;
      rh1 = 1'b0; rh2 = 1'b0; mc = 0; ms = 0; md = 0; exp_state = 0;
      sbq.delete();
    end else begin
      n++;
      rs  = rh2; rh2 = rh1; rh1 = ifc.detector_ready;
      ec  = ifc.calib_req && !cq; cq = ifc.calib_req;
      es  = ifc.shot_req && !sq;  sq = ifc.shot_req;
      gc  = 1'b0; gs = 1'b0;
      if (m_idle && ifc.enable && rs && (pc || ps)) begin
        if (ps) gs = 1'b1; else gc = 1'b1;
        m_idle = 1'b0;
        g      = n;
        if (gs) begin
          if (ms < CMAX) ms++;
          sbq.push_back('{shot: 1'b1, edge_n: n, cnt: ms});
        end else begin
          if (mc < CMAX) mc++;
          sbq.push_back('{shot: 1'b0, edge_n: n, cnt: mc});
        end
      end else if (!m_idle && n >= g + PW + HO + 1 && rs) begin
        m_idle = 1'b1;
      end
      if (ec && pc && !gc) md++;
      if (es && ps && !gs) md++;
      if (md > CMAX) md = CMAX;
      pc = (pc && !gc) || ec;
      ps = (ps && !gs) || es;
      if (m_idle)              exp_state = 0;
      else if (n - g < PW)     exp_state = 1;
      else if (n - g < PW + HO) exp_state = 2;
      else                     exp_state = 3;
    end
  end

  exp_t e;
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].edge_n < n) begin
      fail_now("grant_missed");
      void'(sbq.pop_front());
    end
    if (ifc.calib_grant || ifc.shot_grant) begin
      if (sbq.size() == 0) fail_now("grant_unexpected");
      else begin
        e = sbq.pop_front();
        chk("grant_shot", ifc.shot_grant, e.shot);
        chk("grant_calib", ifc.calib_grant, !e.shot);
        chk("grant_edge", n, e.edge_n);
        chk("grant_count", e.shot ? ifc.shot_count : ifc.calib_count, e.cnt);
      end
    end
    chk("trigger_out", ifc.trigger_out, exp_state == 1);
    chk("arb_state", ifc.arb_state, exp_state);
    chk("busy", ifc.busy, exp_state != 0);
    chk("calib_count", ifc.calib_count, mc);
    chk("shot_count", ifc.shot_count, ms);
    chk("drop_count", ifc.drop_count, md);
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #2;
  endtask

  task automatic pulse_calib();
    ifc.calib_req = 1'b1; tick(1);
    ifc.calib_req = 1'b0; tick(1);
  endtask

  task automatic pulse_shot();
    ifc.shot_req = 1'b1; tick(1);
    ifc.shot_req = 1'b0; tick(1);
  endtask

  initial begin
    reset_signal       = 1'b1;
    ifc.enable         = 1'b1;
    ifc.calib_req      = 1'b0;
    ifc.shot_req       = 1'b0;
    ifc.detector_ready = 1'b1;
    tick(3);
    chk("rst_trigger", ifc.trigger_out, 0);
    chk("rst_state", ifc.arb_state, 0);
    chk("rst_busy", ifc.busy, 0);
    reset_signal = 1'b0;
    tick(5);

    // single calibration trigger
    pulse_calib();
    tick(30);

    // simultaneous requests: shot first, calib afterwards
    ifc.calib_req = 1'b1; ifc.shot_req = 1'b1; tick(1);
    ifc.calib_req = 1'b0; ifc.shot_req = 1'b0; tick(50);

    // three shot edges inside one busy window
    pulse_calib();
    tick(3);
    pulse_shot(); pulse_shot(); pulse_shot();
    tick(40);

    // detector not ready long after holdoff
    pulse_calib();
    ifc.detector_ready = 1'b0;
    pulse_shot();
    tick(PW + HO + 50);
    ifc.detector_ready = 1'b1;
    tick(20);

    // enable low with calib pending, then enable dropped mid-pulse
    ifc.enable = 1'b0;
    pulse_calib();
    tick(100);
    ifc.enable = 1'b1;
    tick(2);
    ifc.enable = 1'b0;
    tick(20);
    ifc.enable = 1'b1;
    tick(10);

    // reset in the second pulse cycle
    ifc.calib_req = 1'b1; tick(1);
    ifc.calib_req = 1'b0; tick(2);
    reset_signal = 1'b1;
    #1;
    chk("midrst_trigger", ifc.trigger_out, 0);
    chk("midrst_state", ifc.arb_state, 0);
    chk("midrst_calib_count", ifc.calib_count, 0);
    chk("midrst_drop_count", ifc.drop_count, 0);
    tick(1);
    reset_signal = 1'b0;
    pulse_calib();
    tick(20);

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      pulse_calib();
      tick(16);
    end
    chk("calib_saturated", ifc.calib_count, CMAX);

    // random traffic
    reset_signal = 1'b1; tick(1);
    reset_signal = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  ifc.calib_req      = !ifc.calib_req;
      if ($urandom_range(0, 7) == 0)  ifc.shot_req       = !ifc.shot_req;
      if ($urandom_range(0, 31) == 0) ifc.enable         = !ifc.enable;
      if ($urandom_range(0, 49) == 0) ifc.detector_ready = !ifc.detector_ready;
      tick(1);
    end

    ifc.calib_req = 1'b0; ifc.shot_req = 1'b0;
    ifc.enable = 1'b1; ifc.detector_ready = 1'b1;
    tick(60);
    if (sbq.size() != 0) fail_now("scoreboard_not_drained");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
